div_tick_monitor: RTL and testbench

- Consumer stage placed directly downstream of the mod-N clock divider. Samples the divider's toggling clk_div output as data in the fast clk domain.
- Emits single-cycle rise/fall enable ticks for downstream logic, so that logic never clocks on clk_div.
- Measures the clk_div period in clk cycles and flags a stalled divider.

---
 rtl/div_mon_pkg.sv | 23 ++
 rtl/div_tick_monitor_if.sv | 25 ++
 rtl/div_edge_sampler.sv | 41 ++++
 rtl/div_tick_monitor.sv | 137 +++++++++++++
 tb/tb_div_tick_monitor.sv | 311 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/div_mon_pkg.sv
// Shared types and constants for the clk_div tick monitor.
// Defining DIV_SYNC_EN adds a two-flop synchroniser ahead of the edge sampler.
package div_mon_pkg;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StAcquire = 2'd1,
    StTrack   = 2'd2,
    StStall   = 2'd3
  } mon_state_e;

`ifdef DIV_SYNC_EN
  localparam int unsigned SYNC_STAGES = 2;
`else
  localparam int unsigned SYNC_STAGES = 0;
`endif

  // All-ones value of a w-bit counter: the saturation point of period and per_cnt.
  function automatic int unsigned cnt_max(int unsigned w);
    return (32'd1 << w) - 32'd1;
  endfunction

endpackage

// File: rtl/div_tick_monitor_if.sv
// Signal bundle between the clk_div source/consumer side (master) and the monitor (slave).
interface div_tick_monitor_if #(
  parameter int unsigned CNT_W = 8
) ();

  logic             en;
  logic             clk_div;
  logic             rise_tick;
  logic             fall_tick;
  logic [CNT_W-1:0] period;
  logic             period_valid;
  logic             stall;
  logic [CNT_W-1:0] edge_cnt;

  modport master (
    output en, clk_div,
    input  rise_tick, fall_tick, period, period_valid, stall, edge_cnt
  );

  modport slave (
    input  en, clk_div,
    output rise_tick, fall_tick, period, period_valid, stall, edge_cnt
  );

endinterface

// File: rtl/div_edge_sampler.sv
// Samples clk_div as data and flags its rising/falling edges combinationally.
// With DIV_SYNC_EN (via SYNC_STAGES) a synchroniser chain precedes the s1/s2 pair.
module div_edge_sampler
  import div_mon_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic clk_div,
  output logic rise,
  output logic fall
);

  logic samp_in;
  logic s1_q;
  logic s2_q;

  if (SYNC_STAGES > 0) begin : g_sync
    logic [SYNC_STAGES-1:0] sync_q;
    always_ff @(posedge clk or posedge rst) begin
      if (rst) sync_q <= '0;
      else     sync_q <= {sync_q[SYNC_STAGES-2:0], clk_div};
    end
    assign samp_in = sync_q[SYNC_STAGES-1];
  end else begin : g_nosync
    assign samp_in = clk_div;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= samp_in;
      s2_q <= s1_q;
    end
  end

  assign rise = s1_q & ~s2_q;
  assign fall = ~s1_q & s2_q;

endmodule

// File: rtl/div_tick_monitor.sv
// Turns a sampled clk_div into rise/fall enable ticks, measures its period and flags stalls.
// Optional DIV_SYNC_EN adds two synchroniser flops in the sampler (period values unchanged).
module div_tick_monitor
  import div_mon_pkg::*;
#(
  parameter int unsigned CNT_W      = 8,
  parameter int unsigned MAX_PERIOD = 16
) (
  input logic               clk,
  input logic               rst,
  div_tick_monitor_if.slave bus
);

  localparam int unsigned       IdleW   = $clog2(MAX_PERIOD + 1);
  localparam logic [CNT_W-1:0]  CntMax  = CNT_W'(cnt_max(CNT_W));
  localparam logic [IdleW-1:0]  IdleSat = IdleW'(MAX_PERIOD);
  localparam logic [IdleW-1:0]  IdleTo  = IdleW'(MAX_PERIOD - 1);

  logic rise;
  logic fall;
  logic timeout;

  mon_state_e       state_q, state_d;
  logic [IdleW-1:0] idle_q, idle_d;
  logic [CNT_W-1:0] per_q, per_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] edge_q, edge_d;
  logic             valid_q, valid_d;
  logic             rise_tick_q, rise_tick_d;
  logic             fall_tick_q, fall_tick_d;
  logic [CNT_W:0]   per_plus;
  logic [CNT_W-1:0] period_new;

  div_edge_sampler u_sampler (
    .clk     (clk),
    .rst     (rst),
    .clk_div (bus.clk_div),
    .rise    (rise),
    .fall    (fall)
  );

  assign timeout    = (idle_q == IdleTo) && !rise && !fall;
  assign per_plus   = {1'b0, per_q} + (CNT_W + 1)'(1);
  // Carry out means per_q was already saturated.
  assign period_new = per_plus[CNT_W] ? CntMax : per_plus[CNT_W-1:0];

  always_comb begin
    state_d     = state_q;
    idle_d      = idle_q;
    per_d       = per_q;
    period_d    = period_q;
    edge_d      = edge_q;
    valid_d     = valid_q;
    rise_tick_d = rise & bus.en & (state_q != StIdle);
    fall_tick_d = fall & bus.en & (state_q != StIdle);

    if (rise || fall)       idle_d = '0;
    else if (idle_q != IdleSat) idle_d = idle_q + IdleW'(1);

    if (rise)                per_d = '0;
    else if (per_q != CntMax) per_d = per_q + CNT_W'(1);

    if (!bus.en) begin
      // Disable wins over any same-cycle edge: everything returns to zero.
      state_d  = StIdle;
      idle_d   = '0;
      per_d    = '0;
      period_d = '0;
      edge_d   = '0;
      valid_d  = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          state_d = StAcquire;
          idle_d  = '0;
          per_d   = '0;
        end
        StAcquire: begin
          if (rise) begin
            state_d = StTrack;
            edge_d  = edge_q + CNT_W'(1);
          end else if (timeout) begin
            state_d = StStall;
          end
        end
        StTrack: begin
          if (rise) begin
            period_d = period_new;
            valid_d  = 1'b1;
            edge_d   = edge_q + CNT_W'(1);
          end else if (timeout) begin
            state_d = StStall;
            valid_d = 1'b0;
          end
        end
        StStall: begin
          // Leaving stall restarts timing; period_valid waits for a full period.
          if (rise) begin
            state_d = StTrack;
            edge_d  = edge_q + CNT_W'(1);
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      idle_q      <= '0;
      per_q       <= '0;
      period_q    <= '0;
      edge_q      <= '0;
      valid_q     <= 1'b0;
      rise_tick_q <= 1'b0;
      fall_tick_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idle_q      <= idle_d;
      per_q       <= per_d;
      period_q    <= period_d;
      edge_q      <= edge_d;
      valid_q     <= valid_d;
      rise_tick_q <= rise_tick_d;
      fall_tick_q <= fall_tick_d;
    end
  end

  assign bus.rise_tick    = rise_tick_q;
  assign bus.fall_tick    = fall_tick_q;
  assign bus.period       = period_q;
  assign bus.period_valid = valid_q;
  assign bus.stall        = (state_q == StStall);
  assign bus.edge_cnt     = edge_q;

endmodule

// File: tb/tb_div_tick_monitor.sv
// Bench for div_tick_monitor: two instances (CNT_W=8/MAX_PERIOD=16 and CNT_W=3/MAX_PERIOD=7)
// checked every cycle against a timestamp-based model, plus table and directed sequences.
module tb_div_tick_monitor;
  import div_mon_pkg::*;

  localparam int D       = int'(SYNC_STAGES);
  localparam int MaxA    = 16;
  localparam int CmaxA   = 255;
  localparam int MaxB    = 7;
  localparam int CmaxB   = 7;
  localparam int HistLen = 16384;
  localparam int MIdle   = 0;
  localparam int MAcq    = 1;
  localparam int MTrack  = 2;
  localparam int MStall  = 3;

  typedef struct {
    int mode;
    int ref_t;   // posedge of the last idle-timer clear
    int rref_t;  // posedge of the last rise (or of leaving idle)
    int period;
    bit valid;
    int edges;
    bit rt;
    bit ft;
  } model_t;

  typedef struct {
    int a_n;
    int b_n;
    int cycles;
    int a_period;
    bit a_valid;
    int b_period;
    bit b_valid;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  div_tick_monitor_if #(.CNT_W(8)) ifa ();
  div_tick_monitor_if #(.CNT_W(3)) ifb ();

  div_tick_monitor #(.CNT_W(8), .MAX_PERIOD(16)) dut_a (.clk(clk), .rst(rst), .bus(ifa.slave));
  div_tick_monitor #(.CNT_W(3), .MAX_PERIOD(7))  dut_b (.clk(clk), .rst(rst), .bus(ifb.slave));

  int     checks = 0;
  int     errors = 0;
  int     t;
  bit     hist_a [HistLen];
  bit     hist_b [HistLen];
  model_t ma, mb;
  int     div_n_a, div_cnt_a, div_n_b, div_cnt_b;
  bit     raw_a, raw_b;
  int     s_a;
  int     last_tick_a;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s t=%0d actual=%0d required=%0d", name, t, act, exp);
    end
  endtask

  function automatic bit ha(input int i);
    return (i < 0 || i >= HistLen) ? 1'b0 : hist_a[i];
  endfunction

  function automatic bit hb(input int i);
    return (i < 0 || i >= HistLen) ? 1'b0 : hist_b[i];
  endfunction

  // One posedge of the behavioural monitor, expressed with timestamps rather than counters.
  function automatic model_t model_step(input model_t m, input int tt, input bit en,
                                        input bit rise, input bit fall,
                                        input int maxp, input int cmax);
    model_t n;
    bit     timeout;
    n       = m;
    timeout = !rise && !fall && (tt - m.ref_t == maxp);
    n.rt    = rise && en && (m.mode != MIdle);
    n.ft    = fall && en && (m.mode != MIdle);
    if (!en) begin
      n.mode = MIdle; n.period = 0; n.valid = 0; n.edges = 0; n.ref_t = tt; n.rref_t = tt;
      return n;
    end
    if (m.mode == MIdle) begin
      n.mode = MAcq; n.ref_t = tt; n.rref_t = tt;
      return n;
    end
    if (rise) begin
      if (m.mode == MTrack) begin
        n.period = (tt - m.rref_t > cmax) ? cmax : tt - m.rref_t;
        n.valid  = 1'b1;
      end
      n.mode  = MTrack;
      n.edges = m.edges + 1;
    end else if (timeout && m.mode != MStall) begin
      n.mode  = MStall;
      n.valid = 1'b0;
    end
    if (rise || fall) n.ref_t = tt;
    if (rise) n.rref_t = tt;
    return n;
  endfunction

  task automatic check_models();
    chk("a_rise_tick", int'(ifa.rise_tick), int'(ma.rt));
    chk("a_fall_tick", int'(ifa.fall_tick), int'(ma.ft));
    chk("a_period", int'(ifa.period), ma.period);
    chk("a_period_valid", int'(ifa.period_valid), int'(ma.valid));
    chk("a_stall", int'(ifa.stall), int'(ma.mode == MStall));
    chk("a_edge_cnt", int'(ifa.edge_cnt), ma.edges & CmaxA);
    chk("b_rise_tick", int'(ifb.rise_tick), int'(mb.rt));
    chk("b_fall_tick", int'(ifb.fall_tick), int'(mb.ft));
    chk("b_period", int'(ifb.period), mb.period);
    chk("b_period_valid", int'(ifb.period_valid), int'(mb.valid));
    chk("b_stall", int'(ifb.stall), int'(mb.mode == MStall));
    chk("b_edge_cnt", int'(ifb.edge_cnt), mb.edges & CmaxB);
  endtask

  task automatic chk_zero(input string pfx);
    chk({pfx, "_a_rise_tick"}, int'(ifa.rise_tick), 0);
    chk({pfx, "_a_fall_tick"}, int'(ifa.fall_tick), 0);
    chk({pfx, "_a_period"}, int'(ifa.period), 0);
    chk({pfx, "_a_period_valid"}, int'(ifa.period_valid), 0);
    chk({pfx, "_a_stall"}, int'(ifa.stall), 0);
    chk({pfx, "_a_edge_cnt"}, int'(ifa.edge_cnt), 0);
    chk({pfx, "_b_period"}, int'(ifb.period), 0);
    chk({pfx, "_b_stall"}, int'(ifb.stall), 0);
    chk({pfx, "_b_edge_cnt"}, int'(ifb.edge_cnt), 0);
  endtask

  task automatic model_reset();
    t           = 0;
    ma          = '{default: 0};
    mb          = '{default: 0};
    s_a         = -1;
    last_tick_a = -1;
  endtask

  // Advance one clk cycle: check at posedge+1, then move the behavioural dividers.
  task automatic tick();
    bit da, db, ea, eb;
    da = ifa.clk_div; db = ifb.clk_div; ea = ifa.en; eb = ifb.en;
    @(posedge clk);
    #1;
    ma = model_step(ma, t, ea, ha(t-1-D) && !ha(t-2-D), !ha(t-1-D) && ha(t-2-D), MaxA, CmaxA);
    mb = model_step(mb, t, eb, hb(t-1-D) && !hb(t-2-D), !hb(t-1-D) && hb(t-2-D), MaxB, CmaxB);
    check_models();
    if (ifa.rise_tick || ifa.fall_tick) last_tick_a = t;
    if (s_a < 0 && da) s_a = t;
    if (t < HistLen) begin
      hist_a[t] = da;
      hist_b[t] = db;
    end
    t++;
    if (raw_a) ifa.clk_div = 1'($urandom_range(0, 1));
    else if (div_n_a != 0) begin
      div_cnt_a++;
      if (div_cnt_a >= div_n_a) begin div_cnt_a = 0; ifa.clk_div = ~ifa.clk_div; end
    end
    if (raw_b) ifb.clk_div = 1'($urandom_range(0, 1));
    else if (div_n_b != 0) begin
      div_cnt_b++;
      if (div_cnt_b >= div_n_b) begin div_cnt_b = 0; ifb.clk_div = ~ifb.clk_div; end
    end
  endtask

  task automatic wait_tick_a(input bit want_fall, input int budget, output int at);
    at = -1;
    for (int i = 0; i < budget; i++) begin
      tick();
      if ((want_fall ? ifa.fall_tick : ifa.rise_tick) == 1'b1) begin
        at = t - 1;
        break;
      end
    end
  endtask

  // The tick is visible in the cycle after posedge S+1+D.
  task automatic measure_first_rise(input string name);
    int at;
    wait_tick_a(1'b0, 40, at);
    chk(name, (at < 0 || s_a < 0) ? -1 : at - s_a, 1 + D);
  endtask

  task automatic async_reset();
    #2 rst = 1'b1;
    #1 chk_zero("arst");
    #1 rst = 1'b0;
    model_reset();
  endtask

  vec_t vecs [4];

  initial begin
    int tr, tf, tr2, ts;
    vecs[0] = '{a_n: 2, b_n: 2, cycles: 40, a_period: 4,  a_valid: 1, b_period: 4, b_valid: 1};
    vecs[1] = '{a_n: 5, b_n: 3, cycles: 60, a_period: 10, a_valid: 1, b_period: 6, b_valid: 1};
    vecs[2] = '{a_n: 1, b_n: 1, cycles: 40, a_period: 2,  a_valid: 1, b_period: 2, b_valid: 1};
    vecs[3] = '{a_n: 3, b_n: 6, cycles: 60, a_period: 6,  a_valid: 1, b_period: 7, b_valid: 1};

    rst = 1'b1;
    ifa.en = 1'b1; ifa.clk_div = 1'b0; ifb.en = 1'b1; ifb.clk_div = 1'b0;
    div_n_a = 0; div_cnt_a = 0; div_n_b = 0; div_cnt_b = 0; raw_a = 0; raw_b = 0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    chk_zero("reset");
    rst = 1'b0;

    // N=3 divider from power-up.
    div_n_a = 3; div_n_b = 6;
    measure_first_rise("first_rise_latency");
    tr = t - 1;
    wait_tick_a(1'b1, 10, tf);
    chk("fall_after_rise", (tf < 0) ? -1 : tf - tr, 3);
    wait_tick_a(1'b0, 10, tr2);
    chk("rise_after_fall", (tr2 < 0 || tf < 0) ? -1 : tr2 - tf, 3);
    chk("period_second_rise", int'(ifa.period), 6);
    chk("valid_second_rise", int'(ifa.period_valid), 1);
    chk("edge_cnt_second_rise", int'(ifa.edge_cnt), 2);

    foreach (vecs[i]) begin
      div_n_a = vecs[i].a_n; div_n_b = vecs[i].b_n;
      for (int c = 0; c < vecs[i].cycles; c++) tick();
      chk($sformatf("vec%0d_a_period", i), int'(ifa.period), vecs[i].a_period);
      chk($sformatf("vec%0d_a_valid", i), int'(ifa.period_valid), int'(vecs[i].a_valid));
      chk($sformatf("vec%0d_b_period", i), int'(ifb.period), vecs[i].b_period);
      chk($sformatf("vec%0d_b_valid", i), int'(ifb.period_valid), int'(vecs[i].b_valid));
    end

    // Divider A stops: stall 16 cycles after its last edge tick.
    div_n_a = 0;
    ts = -1;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (ifa.stall) begin ts = t - 1; break; end
    end
    chk("stall_delay", (ts < 0 || last_tick_a < 0) ? -1 : ts - last_tick_a, 16);
    chk("stall_period_hold", int'(ifa.period), 6);
    chk("stall_valid_drop", int'(ifa.period_valid), 0);

    // Restart while stalled.
    div_n_a = 3; div_cnt_a = 0;
    wait_tick_a(1'b0, 20, tr);
    chk("restart_stall_clear", (tr < 0) ? -1 : int'(ifa.stall), 0);
    chk("restart_valid_still_0", int'(ifa.period_valid), 0);
    wait_tick_a(1'b0, 20, tr2);
    chk("restart_valid_back", (tr2 < 0) ? -1 : int'(ifa.period_valid), 1);
    chk("restart_period", int'(ifa.period), 6);

    // en drops exactly on the posedge where a rise is detected.
    tr = -1;
    for (int i = 0; i < 20; i++) begin
      if (ha(t-1-D) && !ha(t-2-D)) begin tr = t; break; end
      tick();
    end
    chk("en_drop_found_rise", (tr < 0) ? 0 : 1, 1);
    ifa.en = 1'b0;
    tick();
    chk("en_drop_no_tick", int'(ifa.rise_tick), 0);
    chk("en_drop_edge_cnt", int'(ifa.edge_cnt), 0);
    tick();
    chk("en_off_period", int'(ifa.period), 0);
    chk("en_off_valid", int'(ifa.period_valid), 0);
    ifa.en = 1'b1;
    wait_tick_a(1'b0, 20, tr);
    chk("reenable_edge_cnt", (tr < 0) ? -1 : int'(ifa.edge_cnt), 1);
    chk("reenable_valid", int'(ifa.period_valid), 0);

    // Async reset pulse mid-TRACK, away from any clock edge.
    for (int i = 0; i < 20; i++) tick();
    async_reset();
    measure_first_rise("rst_first_rise_latency");

    // Randomised traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 31) == 0) begin
        case ($urandom_range(0, 3))
          0:       begin raw_a = 0; div_n_a = $urandom_range(1, 6); end
          1:       begin raw_a = 0; div_n_a = 0; end
          2:       raw_a = 1;
          default: ifa.en = ($urandom_range(0, 3) != 0);
        endcase
      end
      if ($urandom_range(0, 31) == 0) begin
        case ($urandom_range(0, 3))
          0:       begin raw_b = 0; div_n_b = $urandom_range(1, 6); end
          1:       begin raw_b = 0; div_n_b = 0; end
          2:       raw_b = 1;
          default: ifb.en = ($urandom_range(0, 3) != 0);
        endcase
      end
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog t=%0d actual=timeout required=finish", t);
    $fatal(1, "watchdog");
  end

endmodule
